tpm_fifo_buf_ctrl: RTL and testbench

//  Byte-side controller for the shared 2048x8 / 512x32 TPM command/response buffer.

---
 rtl/tpm_fifo_buf_ctrl_pkg.sv | 17 +
 rtl/tpm_hdr_size_cap.sv | 30 +++
 rtl/tpm_fifo_buf_ctrl.sv | 158 +++++++++++++++
 tb/tb_tpm_fifo_buf_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpm_fifo_buf_ctrl_pkg.sv
// Shared definitions for the TPM FIFO buffer controller: FIFO state encodings
// and the header-size field location inside a TPM command.
package tpm_fifo_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RECEPTION  = 2'd1,
    ST_EXECUTION  = 2'd2,
    ST_COMPLETION = 2'd3
  } fifo_state_e;

  // commandSize occupies command bytes 2..5, most significant byte first
  localparam int         HDR_SIZE_FIRST = 2;
  localparam int         HDR_SIZE_LAST  = 5;
  localparam logic [7:0] RD_IDLE_BYTE   = 8'hFF;

endpackage

// File: rtl/tpm_hdr_size_cap.sv
// Captures the 32-bit big-endian commandSize field as header bytes stream in
// through buffer port B.
module tpm_hdr_size_cap
  import tpm_fifo_buf_ctrl_pkg::*;
#(
  parameter int IDX_W = 12
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_wdata,
  output logic [31:0]      o_hdr_size
);

  logic        w_hit;
  logic [31:0] r_hdr;

  assign w_hit = i_wr && (i_idx >= IDX_W'(HDR_SIZE_FIRST)) && (i_idx <= IDX_W'(HDR_SIZE_LAST));

  // Bytes arrive in index order, so shifting left yields big-endian order
  always_ff @(posedge Clk) begin
    if (Rst || i_clr) r_hdr <= '0;
    else if (w_hit)   r_hdr <= {r_hdr[23:0], i_wdata};
  end

  assign o_hdr_size = r_hdr;

endmodule

// File: rtl/tpm_fifo_buf_ctrl.sv
// Byte-side TPM FIFO controller for the shared command/response buffer:
// sequences IDLE/RECEPTION/EXECUTION/COMPLETION and drives buffer port B.
module tpm_fifo_buf_ctrl
  import tpm_fifo_buf_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int BUF_BYTES = 2048,
  parameter int MIN_CMD   = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  input  logic              cmd_ready,
  input  logic              go,
  output logic              exec_start,
  output logic [ADDR_W:0]   cmd_len,
  input  logic              resp_done,
  input  logic [ADDR_W:0]   resp_len,
  output logic [1:0]        fifo_state,
  output logic              sts_expect,
  output logic              data_avail,
  output logic [ADDR_W:0]   burst_count,
  output logic              overflow,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              buf_we,
  input  logic [7:0]        buf_rdata
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t LP_BUF = ptr_t'(BUF_BYTES);
  localparam ptr_t LP_MIN = ptr_t'(MIN_CMD);

  fifo_state_e r_state, w_state_nxt;
  ptr_t        r_wptr, r_rptr, r_cmd_len, r_resp_len;
  logic        r_ack, r_rd_pend, r_exec_start, r_overflow;
  logic        w_rx_start, w_go_acc, w_resp_acc, w_wr_acc, w_rd_acc, w_ovf_set, w_expect;
  logic [31:0] w_hdr_size;

  tpm_hdr_size_cap #(.IDX_W(ADDR_W + 1)) u_hdr_cap (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_clr      (w_rx_start),
    .i_wr       (w_wr_acc),
    .i_idx      (r_wptr),
    .i_wdata    (host_wdata),
    .o_hdr_size (w_hdr_size)
  );

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // host_req is always decoded against the current (pre-transition) state
  always_comb begin
    w_state_nxt = r_state;
    w_rx_start  = 1'b0;
    w_go_acc    = 1'b0;
    w_resp_acc  = 1'b0;
    w_wr_acc    = 1'b0;
    w_rd_acc    = 1'b0;
    w_ovf_set   = 1'b0;
    w_expect    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_ready) begin
          w_state_nxt = ST_RECEPTION;
          w_rx_start  = 1'b1;
        end
      end
      ST_RECEPTION: begin
        w_expect = (r_wptr < LP_MIN) || (32'(r_wptr) < w_hdr_size);
        if (host_req && host_wr) begin
          if (r_wptr < LP_BUF) w_wr_acc  = 1'b1;
          else                 w_ovf_set = 1'b1;
        end
        if ((r_wptr == LP_MIN) &&
            ((w_hdr_size > 32'(BUF_BYTES)) || (w_hdr_size < 32'(MIN_CMD))))
          w_ovf_set = 1'b1;
        if (cmd_ready) begin
          w_state_nxt = ST_IDLE;
        end else if (go && !w_expect) begin
          w_state_nxt = ST_EXECUTION;
          w_go_acc    = 1'b1;
        end
      end
      ST_EXECUTION: begin
        if (resp_done) begin
          w_state_nxt = ST_COMPLETION;
          w_resp_acc  = 1'b1;
        end
      end
      ST_COMPLETION: begin
        if (host_req) begin
          if (host_wr)                   w_ovf_set = 1'b1;
          else if (r_rptr < r_resp_len)  w_rd_acc  = 1'b1;
        end
        if (cmd_ready) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cmd_len    <= '0;
      r_resp_len   <= '0;
      r_ack        <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_exec_start <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_ack        <= host_req;
      r_rd_pend    <= w_rd_acc;
      r_exec_start <= w_go_acc;
      if (w_rx_start)    r_wptr <= '0;
      else if (w_wr_acc) r_wptr <= r_wptr + ptr_t'(1);
      if (w_rx_start)     r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      // A write landing with go still counts as part of the command
      if (w_go_acc) r_cmd_len <= w_wr_acc ? r_wptr + ptr_t'(1) : r_wptr;
      if (w_resp_acc) begin
        r_rptr     <= '0;
        r_resp_len <= (resp_len > LP_BUF) ? LP_BUF : resp_len;
      end else if (w_rd_acc) begin
        r_rptr <= r_rptr + ptr_t'(1);
      end
    end
  end

  assign buf_we     = w_wr_acc;
  assign buf_wdata  = w_wr_acc ? host_wdata : 8'h00;
  assign buf_addr   = !host_req ? '0 :
                      (r_state == ST_COMPLETION) ? r_rptr[ADDR_W-1:0] : r_wptr[ADDR_W-1:0];

  // buf_rdata is registered in the RAM, so it lines up with the ack cycle
  assign host_rdata = r_rd_pend ? buf_rdata : RD_IDLE_BYTE;
  assign host_ack   = r_ack;
  assign exec_start = r_exec_start;
  assign cmd_len    = r_cmd_len;
  assign overflow   = r_overflow;
  assign fifo_state = r_state;
  assign sts_expect = w_expect;
  assign data_avail = (r_state == ST_COMPLETION) && (r_rptr < r_resp_len);

  always_comb begin
    burst_count = '0;
    if (r_state == ST_RECEPTION)       burst_count = LP_BUF - r_wptr;
    else if (r_state == ST_COMPLETION) burst_count = r_resp_len - r_rptr;
  end

endmodule

// File: tb/tb_tpm_fifo_buf_ctrl.sv
// Directed bench for tpm_fifo_buf_ctrl with a behavioural port-B/port-A RAM
// and a read-data scoreboard queue.
module tb_tpm_fifo_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst, host_req, host_wr, cmd_ready, go, resp_done;
  logic [7:0]  host_wdata, host_rdata, buf_wdata, buf_rdata;
  logic        host_ack, exec_start, sts_expect, data_avail, overflow, buf_we;
  logic [11:0] cmd_len, resp_len, burst_count;
  logic [1:0]  fifo_state;
  logic [10:0] buf_addr;

  logic        pa_we;
  logic [10:0] pa_addr;
  logic [7:0]  pa_data;
  logic [7:0]  mem [0:2047];
  logic [7:0]  sb_q [$];

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int exec_cnt = 0;
  int w0;

  logic [7:0] cmd1 [12] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C,
                            8'h00, 8'h00, 8'h01, 8'h44, 8'hAA, 8'hBB};
  logic [7:0] cmd2 [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20,
                            8'h00, 8'h00, 8'h01, 8'h44};
  logic [7:0] cmd6 [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A,
                            8'h00, 8'h00, 8'h01, 8'h7B};
  logic [7:0] cmdb [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05,
                            8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] resp [6]  = '{8'hC4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  tpm_fifo_buf_ctrl dut (
    .Clk(clk), .Rst(rst),
    .host_req(host_req), .host_wr(host_wr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .cmd_ready(cmd_ready), .go(go), .exec_start(exec_start), .cmd_len(cmd_len),
    .resp_done(resp_done), .resp_len(resp_len),
    .fifo_state(fifo_state), .sts_expect(sts_expect), .data_avail(data_avail),
    .burst_count(burst_count), .overflow(overflow),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata)
  );

  always #5 clk = ~clk;

  // Dual-port buffer: port B from the DUT, port A stands in for the MCU
  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    if (pa_we)  mem[pa_addr]  <= pa_data;
    buf_rdata <= mem[buf_addr];
    if (buf_we)     we_cnt   <= we_cnt + 1;
    if (exec_start) exec_cnt <= exec_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd_ready();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic hwrite(input logic [7:0] b);
    host_req = 1'b1; host_wr = 1'b1; host_wdata = b;
    tick();
    host_req = 1'b0; host_wr = 1'b0; host_wdata = 8'h00;
    chk("wr_ack", host_ack, 1);
  endtask

  task automatic hread(input logic [7:0] exp);
    sb_q.push_back(exp);
    host_req = 1'b1; host_wr = 1'b0;
    tick();
    host_req = 1'b0;
    chk("rd_ack", host_ack, 1);
    if (sb_q.size() > 0) chk("rdata", host_rdata, sb_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; host_req = 0; host_wr = 0; host_wdata = 0; cmd_ready = 0; go = 0;
    resp_done = 0; resp_len = 0; pa_we = 0; pa_addr = 0; pa_data = 0;
    tick(); tick(); tick();
    chk("rst_state", fifo_state, 0);
    chk("rst_rdata", host_rdata, 8'hFF);
    chk("rst_ack", host_ack, 0);
    chk("rst_burst", burst_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_expect", sts_expect, 0);
    chk("rst_cmdlen", cmd_len, 0);
    chk("rst_misc", {exec_start, buf_we, data_avail}, 0);
    rst = 1'b0;
    tick();
    hread(8'hFF);

    // 12-byte command, size field 12, then go
    pulse_cmd_ready();
    chk("t1_state", fifo_state, 1);
    chk("t1_burst0", burst_count, 2048);
    hread(8'hFF);
    w0 = we_cnt;
    for (int i = 0; i < 12; i++) begin
      chk("t1_expect_hi", sts_expect, 1);
      hwrite(cmd1[i]);
    end
    chk("t1_expect_lo", sts_expect, 0);
    chk("t1_burst", burst_count, 2036);
    chk("t1_we_cnt", we_cnt - w0, 12);
    chk("t1_mem11", mem[11], 8'hBB);
    go = 1'b1; tick(); go = 1'b0;
    chk("t1_exec", exec_start, 1);
    chk("t1_state_ex", fifo_state, 2);
    chk("t1_cmdlen", cmd_len, 12);
    tick();
    chk("t1_exec_pulse", exec_start, 0);
    chk("t1_exec_cnt", exec_cnt, 1);
    host_req = 1'b1; host_wr = 1'b1; host_wdata = 8'h5A;
    chk("ex_no_we", buf_we, 0);
    tick();
    host_req = 1'b0; host_wr = 1'b0;
    chk("ex_ack", host_ack, 1);
    chk("ex_ovf", overflow, 0);
    pulse_cmd_ready();
    chk("ex_cmdrdy_ign", fifo_state, 2);
    hread(8'hFF);

    // Response of 6 bytes, 8 reads
    for (int k = 0; k < 6; k++) begin
      pa_we = 1'b1; pa_addr = 11'(k); pa_data = resp[k];
      tick();
    end
    pa_we = 1'b0;
    resp_done = 1'b1; resp_len = 12'd6;
    tick();
    resp_done = 1'b0;
    chk("t4_state", fifo_state, 3);
    chk("t4_avail0", data_avail, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t4_burst", burst_count, (k < 6) ? 6 - k : 0);
      hread((k < 6) ? resp[k] : 8'hFF);
      chk("t4_avail", data_avail, (k < 5) ? 1 : 0);
    end
    hwrite(8'h00);
    chk("t4_wr_ovf", overflow, 1);
    pulse_cmd_ready();
    chk("t4_idle", fifo_state, 0);

    // Header size 0x20 with only 10 bytes: go must be ignored
    pulse_cmd_ready();
    chk("t2_state", fifo_state, 1);
    chk("t2_ovf_clr", overflow, 0);
    for (int i = 0; i < 10; i++) hwrite(cmd2[i]);
    resp_done = 1'b1; resp_len = 12'd4; tick(); resp_done = 1'b0;
    chk("t2_resp_ign", fifo_state, 1);
    go = 1'b1; tick(); go = 1'b0;
    chk("t2_state_go", fifo_state, 1);
    chk("t2_expect", sts_expect, 1);
    chk("t2_no_exec", exec_start, 0);
    tick();
    chk("t2_exec_cnt", exec_cnt, 1);

    // Abort and restart reception
    pulse_cmd_ready();
    chk("t5_abort0", fifo_state, 0);
    pulse_cmd_ready();
    for (int i = 0; i < 5; i++) hwrite(8'(i));
    chk("t5_burst5", burst_count, 2043);
    pulse_cmd_ready();
    chk("t5_abort", fifo_state, 0);
    chk("t5_burst_idle", burst_count, 0);
    pulse_cmd_ready();
    chk("t5_restart", fifo_state, 1);
    chk("t5_burst", burst_count, 2048);

    // go together with the 10th write while expect is still high
    for (int i = 0; i < 9; i++) hwrite(cmd6[i]);
    chk("t6_expect9", sts_expect, 1);
    host_req = 1'b1; host_wr = 1'b1; host_wdata = cmd6[9]; go = 1'b1;
    chk("t6_we", buf_we, 1);
    tick();
    host_req = 1'b0; host_wr = 1'b0; go = 1'b0;
    chk("t6_state", fifo_state, 1);
    chk("t6_no_exec", exec_start, 0);
    chk("t6_expect10", sts_expect, 0);
    chk("t6_burst", burst_count, 2038);
    go = 1'b1; tick(); go = 1'b0;
    chk("t6_state_ex", fifo_state, 2);
    chk("t6_cmdlen", cmd_len, 10);
    resp_done = 1'b1; resp_len = 12'd3000; tick(); resp_done = 1'b0;
    chk("t6_resp_sat", burst_count, 2048);
    pulse_cmd_ready();
    chk("t6_idle", fifo_state, 0);

    // Header size below the minimum header length
    pulse_cmd_ready();
    for (int i = 0; i < 10; i++) hwrite(cmdb[i]);
    chk("hb_ovf_pre", overflow, 0);
    tick();
    chk("hb_ovf", overflow, 1);

    // Fill the whole buffer, then one more byte
    pulse_cmd_ready();
    pulse_cmd_ready();
    chk("t3_ovf_clr", overflow, 0);
    w0 = we_cnt;
    for (int i = 0; i < 2048; i++)
      hwrite((i == 4) ? 8'h08 : ((i >= 2 && i <= 5) ? 8'h00 : 8'(i)));
    chk("t3_ovf_pre", overflow, 0);
    chk("t3_burst", burst_count, 0);
    chk("t3_expect", sts_expect, 0);
    chk("t3_we_cnt", we_cnt - w0, 2048);
    chk("t3_mem100", mem[100], 8'h64);
    host_req = 1'b1; host_wr = 1'b1; host_wdata = 8'hEE;
    chk("t3_drop_we", buf_we, 0);
    tick();
    host_req = 1'b0; host_wr = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_burst_sat", burst_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
